heat_column_responder: RTL and testbench

- Column-side responder for the heat-map column bus: one instance per display column.
- When its column-select bit rises, it latches the row index and the 8-bit signed heat value and writes the value into its private M10K column buffer.
- Acknowledges on return_sig and serves an independent VGA scan-out read port for the same column.
- Sits between the mailbox-reading column-bus initiator and the VGA pixel pipeline.

---
 rtl/heat_column_responder_if.sv | 40 ++++
 rtl/heat_column_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_heat_column_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/heat_column_responder_if.sv
// -----------------------------------------------------------------------------
// heat_column_responder_if
// Column-bus and scan-out bundle for one heat-map display column.
//   master : column-bus initiator plus VGA pixel pipeline side
//   slave  : the column responder
// Signals:
//   col_select  initiator -> responder  level select, held until acknowledged
//   row_select  initiator -> responder  target row (ROW_W)
//   write_data  initiator -> responder  signed heat value (DATA_W)
//   return_sig  responder -> initiator  acknowledge
//   scan_req    pipeline  -> responder  one-cycle scan-out request
//   scan_row    pipeline  -> responder  scan-out row index (ROW_W)
//   scan_data   responder -> pipeline   scan-out value (DATA_W)
//   scan_valid  responder -> pipeline   one-cycle qualifier for scan_data
//   row_err     responder -> initiator  sticky out-of-range write flag
// -----------------------------------------------------------------------------
interface heat_column_responder_if #(
  parameter int ROW_W  = 10,
  parameter int DATA_W = 8
);
  logic              col_select;
  logic [ROW_W-1:0]  row_select;
  logic [DATA_W-1:0] write_data;
  logic              return_sig;
  logic              scan_req;
  logic [ROW_W-1:0]  scan_row;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              row_err;

  modport master (
    output col_select, row_select, write_data, scan_req, scan_row,
    input  return_sig, scan_data, scan_valid, row_err
  );

  modport slave (
    input  col_select, row_select, write_data, scan_req, scan_row,
    output return_sig, scan_data, scan_valid, row_err
  );
endinterface

// File: rtl/heat_column_responder.sv
// -----------------------------------------------------------------------------
// heat_column_responder
// Column-side responder for the heat-map column bus. A rising column select
// latches row and heat value, writes the value into a private M10K column
// buffer and acknowledges with a four-phase handshake. An independent scan-out
// port reads the same buffer for the VGA pixel pipeline (two-cycle latency,
// fully pipelined, read-before-write on address collision).
//
// Ports:
//   clock  system clock (CLOCK_50 domain)
//   reset  asynchronous active-low reset
//   bus    heat_column_responder_if.slave (column bus + scan-out port)
//
// Build option:
//   HEAT_ACCUM_EN  when defined, writes become saturating read-modify-writes
//                  (IDLE, RD, WAIT, ADD, WRITE, ACK). Undefined: plain overwrite.
// -----------------------------------------------------------------------------
module heat_column_responder #(
  parameter int ROWS   = 480,
  parameter int ROW_W  = 10,
  parameter int DATA_W = 8
) (
  input logic                   clock,
  input logic                   reset,
  heat_column_responder_if.slave bus
);

  localparam int               AW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);

`ifdef HEAT_ACCUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ADD   = 3'd3,
    ST_WRITE = 3'd4,
    ST_ACK   = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;
`endif

  state_t            state;
  state_t            state_next;
  logic              latch_en;
  logic              idle_ready;
  logic [ROW_W-1:0]  lat_row;
  logic [DATA_W-1:0] lat_data;
  logic              lat_row_ok;

  logic [DATA_W-1:0] mem [ROWS];
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [AW-1:0]     mem_ra;
  logic [DATA_W-1:0] rd_q;
  logic [ROW_W-1:0]  rd_addr;
  logic              rd_ok;

  logic              scan_go;
  logic [ROW_W-1:0]  scan_addr;
  logic              s1_valid;
  logic              s1_ok;

  assign lat_row_ok = (lat_row < ROWS_L);
  assign mem_we     = (state == ST_WRITE) && lat_row_ok;
  assign mem_wa     = lat_row_ok ? lat_row[AW-1:0] : '0;
  assign rd_ok      = (rd_addr < ROWS_L);
  // Out-of-range reads are pointed at row 0; their data is zeroed at the output
  assign mem_ra     = rd_ok ? rd_addr[AW-1:0] : '0;

`ifdef HEAT_ACCUM_EN
  logic              pend_valid;
  logic [ROW_W-1:0]  pend_row;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] sum_val;

  // Signed add of two DATA_W values, clamped to the representable range
  function automatic logic [DATA_W-1:0] sat_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_add = sum[DATA_W-1:0];
    end
  endfunction

  // Only start a new RMW once no deferred scan is waiting, so the single
  // deferral slot can never overflow
  assign idle_ready = ~pend_valid;
  assign mem_wd     = sum_val;

  // Read-port arbitration: RMW read first, then a deferred scan, then a new scan
  always_comb begin
    scan_go   = 1'b0;
    scan_addr = bus.scan_row;
    rd_addr   = bus.scan_row;
    if (state == ST_RD) begin
      scan_go = 1'b0;
      rd_addr = lat_row;
    end else if (pend_valid) begin
      scan_go   = 1'b1;
      scan_addr = pend_row;
      rd_addr   = pend_row;
    end else begin
      scan_go   = bus.scan_req;
      scan_addr = bus.scan_row;
      rd_addr   = bus.scan_row;
    end
  end

  // Deferral slot for a scan request that lost the read port this cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_row   <= '0;
    end else if (bus.scan_req && ((state == ST_RD) || pend_valid)) begin
      pend_valid <= 1'b1;
      pend_row   <= bus.scan_row;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  // RMW datapath: capture the stored value, then form the saturated sum
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      old_val <= '0;
      sum_val <= '0;
    end else begin
      if (state == ST_WAIT) begin
        old_val <= rd_q;
      end
      if (state == ST_ADD) begin
        sum_val <= sat_add(old_val, lat_data);
      end
    end
  end
`else
  assign idle_ready = 1'b1;
  assign mem_wd     = lat_data;

  // Scan requests own the read port outright
  always_comb begin
    scan_go   = bus.scan_req;
    scan_addr = bus.scan_row;
    rd_addr   = bus.scan_row;
  end
`endif

  // Handshake state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake next-state logic
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.col_select && idle_ready) begin
          latch_en = 1'b1;
`ifdef HEAT_ACCUM_EN
          state_next = ST_RD;
`else
          state_next = ST_WRITE;
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
`ifdef HEAT_ACCUM_EN
      ST_RD:   state_next = ST_WAIT;
      ST_WAIT: state_next = ST_ADD;
      ST_ADD:  state_next = ST_WRITE;
`endif
      ST_WRITE: state_next = ST_ACK;
      ST_ACK: begin
        // Stay acknowledged until select drops; IDLE then needs a fresh rise
        if (!bus.col_select) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ACK;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Row/value capture on the accepting cycle only; later bus changes are ignored
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_row  <= '0;
      lat_data <= '0;
    end else if (latch_en) begin
      lat_row  <= bus.row_select;
      lat_data <= bus.write_data;
    end
  end

  // Registered acknowledge and sticky out-of-range flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.return_sig <= 1'b0;
      bus.row_err    <= 1'b0;
    end else begin
      bus.return_sig <= (state_next == ST_ACK);
      if ((state == ST_WRITE) && !lat_row_ok) begin
        bus.row_err <= 1'b1;
      end
    end
  end

  // M10K column buffer: the read returns the pre-write contents on collision
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    rd_q <= mem[mem_ra];
  end

  // Scan-out pipeline: request stage, then registered output stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid       <= 1'b0;
      s1_ok          <= 1'b0;
      bus.scan_valid <= 1'b0;
      bus.scan_data  <= '0;
    end else begin
      s1_valid       <= scan_go;
      s1_ok          <= (scan_addr < ROWS_L);
      bus.scan_valid <= s1_valid;
      if (s1_valid) begin
        bus.scan_data <= s1_ok ? rd_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_heat_column_responder.sv
// -----------------------------------------------------------------------------
// tb_heat_column_responder
// Self-checking bench: a table of writes applied in a loop, scan-outs checked
// through an expected-value queue, plus hand-written multi-cycle sequences
// (held select, streaming collision, reset mid-handshake, out-of-range rows).
// -----------------------------------------------------------------------------
module tb_heat_column_responder;

`ifdef HEAT_ACCUM_EN
  localparam int ACK_LAT = 5;
`else
  localparam int ACK_LAT = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  heat_column_responder_if #(.ROW_W(10), .DATA_W(8)) bus ();

  heat_column_responder #(.ROWS(480), .ROW_W(10), .DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] row;
    logic [7:0] data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         due;
    string      name;
  } exp_t;

  vec_t       vecs [10];
  exp_t       sbq [$];
  logic [7:0] model [1024];
  logic [7:0] last_exp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] tb_sat(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic void model_write(input logic [9:0] row, input logic [7:0] data);
    if (row < 10'd480) begin
`ifdef HEAT_ACCUM_EN
      model[row] = tb_sat(model[row], data);
`else
      model[row] = data;
`endif
    end
  endfunction

  // Scoreboard side: every scan_valid pops one expectation
  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.scan_valid) begin
      if (sbq.size() == 0) begin
        check("spurious scan_valid", {31'b0, bus.scan_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check({e.name, " data"}, {24'b0, bus.scan_data}, {24'b0, e.data});
        check({e.name, " cycle"}, cyc, e.due);
      end
    end
  end

  // Issue one scan request this cycle (caller lowers scan_req when done)
  task automatic scan_issue(input logic [9:0] row, input string name);
    exp_t e;
    bus.scan_req = 1'b1;
    bus.scan_row = row;
    e.data = (row < 10'd480) ? model[row] : 8'h00;
    e.due  = cyc + 2;
    e.name = name;
    last_exp = e.data;
    sbq.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic drain(input string name);
    int n;
    bus.scan_req = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, " queue empty"}, sbq.size(), 0);
  endtask

  // Full four-phase write; checks acknowledge latency and release
  task automatic do_write(input logic [9:0] row, input logic [7:0] data, input string name);
    int lat;
    bus.col_select = 1'b1;
    bus.row_select = row;
    bus.write_data = data;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!bus.return_sig && lat < 20);
    check({name, " ack latency"}, lat, ACK_LAT);
    model_write(row, data);
    bus.col_select = 1'b0;
    @(posedge clock); #1;
    check({name, " ack release"}, {31'b0, bus.return_sig}, 32'd0);
  endtask

  initial begin
    int bad;
    int lat;
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    vecs[0] = '{10'd17,  8'h5A, 1'b0};
    vecs[1] = '{10'd0,   8'h10, 1'b0};
    vecs[2] = '{10'd1,   8'h81, 1'b0};
    vecs[3] = '{10'd2,   8'h7F, 1'b0};
    vecs[4] = '{10'd3,   8'h33, 1'b0};
    vecs[5] = '{10'd4,   8'hC0, 1'b0};
    vecs[6] = '{10'd5,   8'h05, 1'b0};
    vecs[7] = '{10'd6,   8'h66, 1'b0};
    vecs[8] = '{10'd7,   8'hF0, 1'b0};
    vecs[9] = '{10'd479, 8'hA5, 1'b0};

    bus.col_select = 1'b0;
    bus.row_select = 10'd0;
    bus.write_data = 8'h00;
    bus.scan_req   = 1'b0;
    bus.scan_row   = 10'd0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset return_sig", {31'b0, bus.return_sig}, 32'd0);
    check("reset scan_valid", {31'b0, bus.scan_valid}, 32'd0);
    check("reset scan_data", {24'b0, bus.scan_data}, 32'd0);
    check("reset row_err", {31'b0, bus.row_err}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Table-driven writes, then scan every written row back
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].row, vecs[i].data, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d row_err", i), {31'b0, bus.row_err}, {31'b0, vecs[i].exp_err});
    end
    for (int i = 0; i < 10; i++) begin
      scan_issue(vecs[i].row, $sformatf("scan tbl%0d", i));
    end
    drain("table scan");

    // Out-of-range write completes the handshake but only raises row_err
    do_write(10'd480, 8'h11, "oor");
    check("oor row_err", {31'b0, bus.row_err}, 32'd1);
    scan_issue(10'd0, "oor row0");
    scan_issue(10'd479, "oor row479");
    scan_issue(10'd480, "scan row480");
    scan_issue(10'd1023, "scan row1023");
    drain("oor scan");
    repeat (3) @(posedge clock);
    #1;
    check("scan_data hold", {24'b0, bus.scan_data}, {24'b0, last_exp});

    // Held select: one write only, later data changes ignored
    bus.col_select = 1'b1;
    bus.row_select = 10'd20;
    bus.write_data = 8'h01;
    bad = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (i == 3) bus.write_data = 8'h02;
      if (bus.return_sig && lat == 0) lat = i;
      if (i >= ACK_LAT && !bus.return_sig) bad++;
    end
    check("held ack latency", lat, ACK_LAT);
    check("held ack steady", bad, 0);
    model_write(10'd20, 8'h01);
    bus.col_select = 1'b0;
    @(posedge clock); #1;
    check("held ack release", {31'b0, bus.return_sig}, 32'd0);
    scan_issue(10'd20, "held row20");
    drain("held scan");

`ifndef HEAT_ACCUM_EN
    // Streaming scan rows 0..7; the write to row 3 lands on row 3's read edge
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        bus.col_select = 1'b1;
        bus.row_select = 10'd3;
        bus.write_data = 8'hE7;
      end
      scan_issue(10'(k), $sformatf("stream row%0d", k));
    end
    bus.scan_req = 1'b0;
    check("collide ack", {31'b0, bus.return_sig}, 32'd1);
    model_write(10'd3, 8'hE7);
    bus.col_select = 1'b0;
    @(posedge clock); #1;
    check("collide ack release", {31'b0, bus.return_sig}, 32'd0);
    drain("stream");
    scan_issue(10'd3, "rescan row3");
    drain("rescan");
`else
    // Saturating accumulate on a row that has not been written yet
    do_write(10'd100, 8'h70, "acc base");
    do_write(10'd100, 8'h20, "acc sat");
    check("acc model sat", {24'b0, model[100]}, 32'h7F);
    scan_issue(10'd100, "acc row100 sat");
    drain("acc sat scan");
    do_write(10'd100, 8'h80, "acc neg");
    scan_issue(10'd100, "acc row100 neg");
    drain("acc neg scan");
    check("acc model neg", {24'b0, model[100]}, 32'hFF);
`endif

    // Reset while acknowledging: return_sig must drop without a clock edge
    bus.col_select = 1'b1;
    bus.row_select = 10'd9;
    bus.write_data = 8'h99;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!bus.return_sig && lat < 20);
    check("rst ack reached", {31'b0, bus.return_sig}, 32'd1);
    model_write(10'd9, 8'h99);
    #2;
    reset = 1'b0;
    #1;
    check("rst async return_sig", {31'b0, bus.return_sig}, 32'd0);
    bus.col_select = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst row_err cleared", {31'b0, bus.row_err}, 32'd0);
    check("rst return_sig low", {31'b0, bus.return_sig}, 32'd0);
    do_write(10'd10, 8'h42, "post rst");
    scan_issue(10'd9, "post rst row9");
    scan_issue(10'd10, "post rst row10");
    scan_issue(10'd17, "post rst row17");
    drain("post rst scan");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
